// File: rtl/eh2_pkg.sv
// rtl/eh2_pkg.sv - shared types and defaults for the EX-stage ALU issue arbiter
package eh2_pkg;

  localparam int ALU_PKT_W = 160;

  typedef struct packed {
    logic [ALU_PKT_W-1:0] pkt;
    logic                 is_br;
  } eh2_alu_arb_entry_t;

endpackage

// File: rtl/eh2_exu_alu_arb_buf.sv
// rtl/eh2_exu_alu_arb_buf.sv - per-thread 1-entry op holding buffer with branch-block flag
module eh2_exu_alu_arb_buf
  import eh2_pkg::*;
#(
  parameter int PKT_W = ALU_PKT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_is_br,
  input  logic [PKT_W-1:0] req_pkt,
  input  logic             kill,
  input  logic             issue,
  input  logic             resolve,
  output logic             buf_v,
  output logic             blk,
  output logic [PKT_W-1:0] pkt
);

  logic is_br;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_v <= 1'b0;
      blk   <= 1'b0;
      is_br <= 1'b0;
      pkt   <= '0;
    end else begin
      // kill drops both the held op and any op offered in the same cycle
      if (kill) begin
        buf_v <= 1'b0;
      end else if (req_valid && !buf_v) begin
        buf_v <= 1'b1;
        pkt   <= req_pkt;
        is_br <= req_is_br;
      end else if (issue) begin
        buf_v <= 1'b0;
      end

      if (issue && is_br) begin
        blk <= 1'b1;
      end else if (kill || resolve) begin
        blk <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/eh2_exu_alu_arb.sv
// rtl/eh2_exu_alu_arb.sv - round-robin issue arbiter for the shared EX-stage ALU
module eh2_exu_alu_arb
  import eh2_pkg::*;
#(
  parameter int NUM_THREADS = 2,
  parameter int PKT_W       = ALU_PKT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_THREADS-1:0]       flush,
  input  logic                         alu_stall,
  input  logic [NUM_THREADS-1:0]       req_valid,
  output logic [NUM_THREADS-1:0]       req_ready,
  input  logic [NUM_THREADS-1:0]       req_is_br,
  input  logic [NUM_THREADS*PKT_W-1:0] req_pkt,
  output logic                         alu_valid,
  output logic                         alu_enable,
  output logic                         alu_tid,
  output logic [PKT_W-1:0]             alu_pkt,
  input  logic                         res_valid,
  input  logic                         res_tid,
  input  logic [NUM_THREADS-1:0]       res_flush,
  output logic [NUM_THREADS-1:0]       blocked
);

  logic [NUM_THREADS-1:0] buf_v;
  logic [NUM_THREADS-1:0] blk;
  logic [NUM_THREADS-1:0] kill;
  logic [NUM_THREADS-1:0] elig;
  logic [NUM_THREADS-1:0] issue;
  logic [PKT_W-1:0]       buf_pkt [NUM_THREADS];
  logic                   sel_any;
  logic                   sel_tid;

  assign kill      = flush | res_flush;
  assign elig      = buf_v & ~blk & ~kill & {NUM_THREADS{~alu_stall}};
  assign req_ready = ~buf_v;
  assign blocked   = blk;

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
    assign issue[t] = sel_any && (sel_tid == 1'(t));

    eh2_exu_alu_arb_buf #(.PKT_W(PKT_W)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[t]),
      .req_is_br (req_is_br[t]),
      .req_pkt   (req_pkt[t*PKT_W +: PKT_W]),
      .kill      (kill[t]),
      .issue     (issue[t]),
      .resolve   (res_valid && (res_tid == 1'(t))),
      .buf_v     (buf_v[t]),
      .blk       (blk[t]),
      .pkt       (buf_pkt[t])
    );
  end

  if (NUM_THREADS == 1) begin : g_sel1
    assign sel_any = elig[0];
    assign sel_tid = 1'b0;
  end else begin : g_sel2
    logic rr_ptr;

    always_comb begin
      sel_any = 1'b0;
      sel_tid = 1'b0;
      if (elig[rr_ptr]) begin
        sel_any = 1'b1;
        sel_tid = rr_ptr;
      end else if (elig[~rr_ptr]) begin
        sel_any = 1'b1;
        sel_tid = ~rr_ptr;
      end
    end

    // pointer only moves on a real issue, so a stall keeps the preferred thread
    always_ff @(posedge clk) begin
      if (rst) begin
        rr_ptr <= 1'b0;
      end else if (sel_any) begin
        rr_ptr <= ~sel_tid;
      end
    end
  end

  assign alu_valid  = sel_any;
  assign alu_enable = sel_any;
  assign alu_tid    = sel_tid;
  assign alu_pkt    = sel_any ? buf_pkt[sel_tid] : '0;

  a_one_issue : assert property (@(posedge clk) disable iff (rst) $onehot0(issue));
  a_issue_ok  : assert property (@(posedge clk) disable iff (rst)
                                 alu_valid |-> (buf_v[alu_tid] && !blk[alu_tid]));
  a_no_flush  : assert property (@(posedge clk) disable iff (rst) (issue & flush) == '0);

endmodule

// File: tb/tb_eh2_exu_alu_arb.sv
// tb/tb_eh2_exu_alu_arb.sv - scoreboard bench for the EX-stage ALU issue arbiter
module tb_eh2_exu_alu_arb;

  localparam int NT = 2;
  localparam int PW = 160;

  logic              clk = 1'b0;
  logic              rst;
  logic [NT-1:0]     flush;
  logic              alu_stall;
  logic [NT-1:0]     req_valid;
  logic [NT-1:0]     req_ready;
  logic [NT-1:0]     req_is_br;
  logic [NT*PW-1:0]  req_pkt;
  logic              alu_valid;
  logic              alu_enable;
  logic              alu_tid;
  logic [PW-1:0]     alu_pkt;
  logic              res_valid;
  logic              res_tid;
  logic [NT-1:0]     res_flush;
  logic [NT-1:0]     blocked;

  int errors = 0;
  int checks = 0;
  int seq    = 0;
  logic [PW-1:0] sbq0 [$];
  logic [PW-1:0] sbq1 [$];

  eh2_exu_alu_arb #(.NUM_THREADS(NT), .PKT_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .alu_stall  (alu_stall),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_is_br  (req_is_br),
    .req_pkt    (req_pkt),
    .alu_valid  (alu_valid),
    .alu_enable (alu_enable),
    .alu_tid    (alu_tid),
    .alu_pkt    (alu_pkt),
    .res_valid  (res_valid),
    .res_tid    (res_tid),
    .res_flush  (res_flush),
    .blocked    (blocked)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mkpkt(int t, int n);
    logic [7:0] b;
    b = 8'(17 * (t + 1));
    return {{19{b}}, 8'(n)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pkts();
    req_pkt = {mkpkt(1, seq), mkpkt(0, seq)};
    seq++;
  endtask

  task automatic clear_inputs();
    flush = '0; alu_stall = 1'b0; req_valid = '0; req_is_br = '0;
    res_valid = 1'b0; res_tid = 1'b0; res_flush = '0; req_pkt = '0;
  endtask

  // records what the bench offered and the buffer took; flush/reset discard held ops
  task automatic note_accept();
    if (rst) begin
      sbq0.delete();
      sbq1.delete();
    end else begin
      if (flush[0] || res_flush[0]) sbq0.delete();
      else if (req_valid[0] && req_ready[0]) sbq0.push_back(req_pkt[0 +: PW]);
      if (flush[1] || res_flush[1]) sbq1.delete();
      else if (req_valid[1] && req_ready[1]) sbq1.push_back(req_pkt[PW +: PW]);
    end
  endtask

  task automatic sb_pop(input int t, output logic [PW-1:0] p, output bit ok);
    ok = 1'b0;
    p  = '0;
    if (t == 0 && sbq0.size() > 0) begin p = sbq0.pop_front(); ok = 1'b1; end
    else if (t == 1 && sbq1.size() > 0) begin p = sbq1.pop_front(); ok = 1'b1; end
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst = 1'b1;
    sbq0.delete();
    sbq1.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks += 6;
    if (alu_valid !== 1'b0)  begin errors++; $display("FAIL reset alu_valid: got %b want 0", alu_valid); end
    if (alu_enable !== 1'b0) begin errors++; $display("FAIL reset alu_enable: got %b want 0", alu_enable); end
    if (alu_tid !== 1'b0)    begin errors++; $display("FAIL reset alu_tid: got %b want 0", alu_tid); end
    if (alu_pkt !== '0)      begin errors++; $display("FAIL reset alu_pkt: got %h want 0", alu_pkt); end
    if (blocked !== 2'b00)   begin errors++; $display("FAIL reset blocked: got %b want 00", blocked); end
    if (req_ready !== 2'b11) begin errors++; $display("FAIL reset req_ready: got %b want 11", req_ready); end
    tick();
  endtask

  task automatic test_alternate();
    logic [PW-1:0] exp;
    bit ok;
    logic [1:0] er;
    reset_dut();
    for (int k = 0; k < 10; k++) begin
      req_valid = 2'b11;
      req_is_br = 2'b00;
      drive_pkts();
      @(negedge clk);
      er = (k == 0) ? 2'b11 : (k == 1) ? 2'b00 : (k % 2 == 0) ? 2'b01 : 2'b10;
      checks += 4;
      if ({alu_valid, alu_enable} !== {2{k > 0}}) begin
        errors++; $display("FAIL alt valid c%0d: got %b%b want %0d", k, alu_valid, alu_enable, k > 0);
      end
      if (req_ready !== er) begin
        errors++; $display("FAIL alt ready c%0d: got %b want %b", k, req_ready, er);
      end
      if (blocked !== 2'b00) begin
        errors++; $display("FAIL alt blocked c%0d: got %b want 00", k, blocked);
      end
      if (k > 0) begin
        sb_pop((k + 1) % 2, exp, ok);
        if (!ok || alu_tid !== 1'((k + 1) % 2) || alu_pkt !== exp) begin
          errors++; $display("FAIL alt issue c%0d: got tid %b pkt %h want tid %0d pkt %h", k, alu_tid, alu_pkt, (k + 1) % 2, exp);
        end
      end else if (alu_pkt !== '0) begin
        errors++; $display("FAIL alt idle pkt c%0d: got %h want 0", k, alu_pkt);
      end
      note_accept();
      tick();
    end
  endtask

  task automatic test_branch_block();
    int v0 [7] = '{1, 1, 1, 0, 0, 0, 0};
    int b0 [7] = '{1, 0, 0, 0, 0, 0, 0};
    int rv [7] = '{0, 0, 0, 1, 1, 0, 0};
    int rt [7] = '{0, 0, 0, 1, 0, 0, 0};
    int ev [7] = '{0, 1, 0, 0, 0, 1, 0};
    int er [7] = '{3, 2, 3, 2, 2, 2, 3};
    int eb [7] = '{0, 0, 1, 1, 1, 0, 0};
    logic [PW-1:0] exp;
    bit ok;
    reset_dut();
    for (int k = 0; k < 7; k++) begin
      req_valid = {1'b0, 1'(v0[k])};
      req_is_br = {1'b0, 1'(b0[k])};
      res_valid = 1'(rv[k]);
      res_tid   = 1'(rt[k]);
      drive_pkts();
      @(negedge clk);
      checks += 4;
      if ({alu_valid, alu_enable} !== {2{1'(ev[k])}}) begin
        errors++; $display("FAIL br valid c%0d: got %b%b want %0d", k, alu_valid, alu_enable, ev[k]);
      end
      if (req_ready !== 2'(er[k])) begin
        errors++; $display("FAIL br ready c%0d: got %b want %0d", k, req_ready, er[k]);
      end
      if (blocked !== 2'(eb[k])) begin
        errors++; $display("FAIL br blocked c%0d: got %b want %0d", k, blocked, eb[k]);
      end
      if (ev[k] != 0) begin
        sb_pop(0, exp, ok);
        if (!ok || alu_tid !== 1'b0 || alu_pkt !== exp) begin
          errors++; $display("FAIL br issue c%0d: got tid %b pkt %h want tid 0 pkt %h", k, alu_tid, alu_pkt, exp);
        end
      end else if (alu_pkt !== '0) begin
        errors++; $display("FAIL br idle pkt c%0d: got %h want 0", k, alu_pkt);
      end
      note_accept();
      tick();
    end
  endtask

  task automatic test_other_thread();
    int b0 [10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int rv [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int ev [10] = '{0, 1, 1, 0, 1, 0, 1, 0, 1, 1};
    int et [10] = '{0, 0, 1, 0, 1, 0, 1, 0, 0, 1};
    int er [10] = '{3, 0, 1, 2, 0, 2, 0, 2, 0, 1};
    int eb [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 0};
    logic [PW-1:0] exp;
    bit ok;
    reset_dut();
    for (int k = 0; k < 10; k++) begin
      req_valid = 2'b11;
      req_is_br = {1'b0, 1'(b0[k])};
      res_valid = 1'(rv[k]);
      res_tid   = 1'b0;
      drive_pkts();
      @(negedge clk);
      checks += 4;
      if ({alu_valid, alu_enable} !== {2{1'(ev[k])}}) begin
        errors++; $display("FAIL oth valid c%0d: got %b%b want %0d", k, alu_valid, alu_enable, ev[k]);
      end
      if (req_ready !== 2'(er[k])) begin
        errors++; $display("FAIL oth ready c%0d: got %b want %0d", k, req_ready, er[k]);
      end
      if (blocked !== 2'(eb[k])) begin
        errors++; $display("FAIL oth blocked c%0d: got %b want %0d", k, blocked, eb[k]);
      end
      if (ev[k] != 0) begin
        sb_pop(et[k], exp, ok);
        if (!ok || alu_tid !== 1'(et[k]) || alu_pkt !== exp) begin
          errors++; $display("FAIL oth issue c%0d: got tid %b pkt %h want tid %0d pkt %h", k, alu_tid, alu_pkt, et[k], exp);
        end
      end else if (alu_pkt !== '0) begin
        errors++; $display("FAIL oth idle pkt c%0d: got %h want 0", k, alu_pkt);
      end
      note_accept();
      tick();
    end
  endtask

  task automatic test_flush();
    int v0 [6] = '{1, 1, 1, 0, 0, 0};
    int v1 [6] = '{0, 1, 1, 1, 1, 0};
    int st [6] = '{0, 0, 1, 0, 0, 0};
    int f1 [6] = '{0, 0, 0, 1, 1, 0};
    int ev [6] = '{0, 1, 0, 1, 0, 0};
    int er [6] = '{3, 2, 1, 0, 3, 3};
    logic [PW-1:0] exp;
    bit ok;
    reset_dut();
    for (int k = 0; k < 6; k++) begin
      req_valid = {1'(v1[k]), 1'(v0[k])};
      alu_stall = 1'(st[k]);
      flush     = {1'(f1[k]), 1'b0};
      drive_pkts();
      @(negedge clk);
      checks += 4;
      if ({alu_valid, alu_enable} !== {2{1'(ev[k])}}) begin
        errors++; $display("FAIL fl valid c%0d: got %b%b want %0d", k, alu_valid, alu_enable, ev[k]);
      end
      if (req_ready !== 2'(er[k])) begin
        errors++; $display("FAIL fl ready c%0d: got %b want %0d", k, req_ready, er[k]);
      end
      if (blocked !== 2'b00) begin
        errors++; $display("FAIL fl blocked c%0d: got %b want 00", k, blocked);
      end
      if (ev[k] != 0) begin
        sb_pop(0, exp, ok);
        if (!ok || alu_tid !== 1'b0 || alu_pkt !== exp) begin
          errors++; $display("FAIL fl issue c%0d: got tid %b pkt %h want tid 0 pkt %h", k, alu_tid, alu_pkt, exp);
        end
      end else if (alu_pkt !== '0) begin
        errors++; $display("FAIL fl idle pkt c%0d: got %h want 0", k, alu_pkt);
      end
      note_accept();
      tick();
    end
  endtask

  task automatic test_stall();
    int st [8] = '{0, 0, 1, 1, 1, 0, 0, 0};
    int ev [8] = '{0, 1, 0, 0, 0, 1, 1, 1};
    int et [8] = '{0, 0, 0, 0, 0, 1, 0, 1};
    int er [8] = '{3, 0, 1, 0, 0, 0, 2, 1};
    logic [PW-1:0] exp;
    bit ok;
    reset_dut();
    for (int k = 0; k < 8; k++) begin
      req_valid = 2'b11;
      alu_stall = 1'(st[k]);
      drive_pkts();
      @(negedge clk);
      checks += 3;
      if ({alu_valid, alu_enable} !== {2{1'(ev[k])}}) begin
        errors++; $display("FAIL st valid c%0d: got %b%b want %0d", k, alu_valid, alu_enable, ev[k]);
      end
      if (req_ready !== 2'(er[k])) begin
        errors++; $display("FAIL st ready c%0d: got %b want %0d", k, req_ready, er[k]);
      end
      if (ev[k] != 0) begin
        sb_pop(et[k], exp, ok);
        if (!ok || alu_tid !== 1'(et[k]) || alu_pkt !== exp) begin
          errors++; $display("FAIL st issue c%0d: got tid %b pkt %h want tid %0d pkt %h", k, alu_tid, alu_pkt, et[k], exp);
        end
      end else if (alu_pkt !== '0) begin
        errors++; $display("FAIL st idle pkt c%0d: got %h want 0", k, alu_pkt);
      end
      note_accept();
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int v0 [7] = '{1, 1, 1, 1, 0, 1, 0};
    int v1 [7] = '{1, 1, 1, 1, 0, 0, 0};
    int b0 [7] = '{1, 0, 0, 0, 0, 0, 0};
    int st [7] = '{0, 0, 1, 1, 0, 0, 0};
    int rs [7] = '{0, 0, 0, 1, 0, 0, 0};
    int ev [7] = '{0, 1, 0, 0, 0, 0, 1};
    int er [7] = '{3, 0, 1, 0, 3, 3, 2};
    int eb [7] = '{0, 0, 1, 1, 0, 0, 0};
    logic [PW-1:0] exp;
    bit ok;
    reset_dut();
    for (int k = 0; k < 7; k++) begin
      req_valid = {1'(v1[k]), 1'(v0[k])};
      req_is_br = {1'b0, 1'(b0[k])};
      alu_stall = 1'(st[k]);
      rst       = 1'(rs[k]);
      drive_pkts();
      @(negedge clk);
      checks += 5;
      if ({alu_valid, alu_enable} !== {2{1'(ev[k])}}) begin
        errors++; $display("FAIL rm valid c%0d: got %b%b want %0d", k, alu_valid, alu_enable, ev[k]);
      end
      if (req_ready !== 2'(er[k])) begin
        errors++; $display("FAIL rm ready c%0d: got %b want %0d", k, req_ready, er[k]);
      end
      if (blocked !== 2'(eb[k])) begin
        errors++; $display("FAIL rm blocked c%0d: got %b want %0d", k, blocked, eb[k]);
      end
      if (ev[k] == 0 && alu_tid !== 1'b0) begin
        errors++; $display("FAIL rm idle tid c%0d: got %b want 0", k, alu_tid);
      end
      if (ev[k] != 0) begin
        sb_pop(0, exp, ok);
        if (!ok || alu_tid !== 1'b0 || alu_pkt !== exp) begin
          errors++; $display("FAIL rm issue c%0d: got tid %b pkt %h want tid 0 pkt %h", k, alu_tid, alu_pkt, exp);
        end
      end else if (alu_pkt !== '0) begin
        errors++; $display("FAIL rm idle pkt c%0d: got %h want 0", k, alu_pkt);
      end
      note_accept();
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_branch_block();
    test_other_thread();
    test_flush();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
